// File: rtl/cache_mem_burst_slave_if.sv
// Avalon-MM burst port between the cache m0 master and the memory-side slave.
// Clock and reset are not part of the bundle; they stay plain module ports.
interface cache_mem_burst_slave_if #(
  parameter int BURST_W = 8
);
  logic [31:0]        s0_address;
  logic [3:0]         s0_byteEnable;
  logic               s0_read;
  logic               s0_write;
  logic [31:0]        s0_writeData;
  logic               s0_beginBurstTransfer;
  logic [BURST_W-1:0] s0_burstCount;
  logic               s0_waitRequest;
  logic [31:0]        s0_readData;
  logic               s0_readDataValid;

  modport master (
    output s0_address, s0_byteEnable, s0_read, s0_write, s0_writeData,
           s0_beginBurstTransfer, s0_burstCount,
    input  s0_waitRequest, s0_readData, s0_readDataValid
  );

  modport slave (
    input  s0_address, s0_byteEnable, s0_read, s0_write, s0_writeData,
           s0_beginBurstTransfer, s0_burstCount,
    output s0_waitRequest, s0_readData, s0_readDataValid
  );
endinterface

// File: rtl/cache_mem_burst_slave.sv
// Avalon-MM burst responder backing a word-addressed on-chip RAM.
// One outstanding transaction, per-beat byte enables, fixed read latency.
// Optional: define CACHE_MEM_SLV_WAIT_INJECT_EN to add LFSR-driven waitRequest
// stalls in IDLE/WR_BURST for cache stall stress.
module cache_mem_burst_slave #(
  parameter int DEPTH    = 1024,
  parameter int BURST_W  = 8,
  parameter int READ_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rest,
  cache_mem_burst_slave_if.slave  s0
);
  localparam int AW = $clog2(DEPTH);
  // RD_WAIT holds READ_LAT-1 cycles; the counter starts at READ_LAT-2 and fires at 0.
  localparam logic [1:0] LAT_INIT = 2'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

  state_t             r_state, w_state_n;
  logic [AW-1:0]      r_addr, w_addr_n;
  logic [BURST_W-1:0] r_rem, w_rem_n;
  logic [1:0]         r_lat, w_lat_n;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic               r_rvalid;
  logic [31:0]        r_mem [DEPTH];

  logic               w_wait;
  logic               w_inject;
  logic               w_we;
  logic [AW-1:0]      w_waddr;
  logic               w_fire;
  logic [AW-1:0]      w_raddr;
  logic [AW-1:0]      w_word;
  logic [BURST_W-1:0] w_bc;

  assign w_word = s0.s0_address[AW+1:2];
  // A zero burst count is a single beat.
  assign w_bc   = (s0.s0_burstCount == '0) ? BURST_W'(1) : s0.s0_burstCount;

  // Address bits outside the word index and the begin-burst marker carry no decode meaning.
  logic w_unused_ok;
  assign w_unused_ok = ^{s0.s0_address[31:AW+2], s0.s0_address[1:0], s0.s0_beginBurstTransfer};

`ifdef CACHE_MEM_SLV_WAIT_INJECT_EN
  logic [15:0] r_lfsr;
  // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_inject = (r_lfsr[1:0] == 2'b00);
`else
  assign w_inject = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  // Next state, stall, RAM write strobe and read-beat issue.
  always_comb begin
    w_state_n = r_state;
    w_wait    = 1'b1;
    w_we      = 1'b0;
    w_waddr   = r_addr;
    w_fire    = 1'b0;
    w_raddr   = r_addr;
    w_addr_n  = r_addr;
    w_rem_n   = r_rem;
    w_lat_n   = r_lat;
    case (r_state)
      IDLE: begin
        w_wait = !r_ready || w_inject;
        if (!w_wait && s0.s0_write) begin
          // Write has priority over a simultaneous read.
          w_we     = 1'b1;
          w_waddr  = w_word;
          w_addr_n = w_word + AW'(1);
          w_rem_n  = w_bc - BURST_W'(1);
          if (w_bc != BURST_W'(1)) w_state_n = WR_BURST;
        end else if (!w_wait && s0.s0_read) begin
          if (READ_LAT == 1) begin
            w_fire    = 1'b1;
            w_raddr   = w_word;
            w_addr_n  = w_word + AW'(1);
            w_rem_n   = w_bc - BURST_W'(1);
            w_state_n = RD_BURST;
          end else begin
            w_addr_n  = w_word;
            w_rem_n   = w_bc;
            w_lat_n   = LAT_INIT;
            w_state_n = RD_WAIT;
          end
        end
      end
      WR_BURST: begin
        w_wait = w_inject;
        if (!w_wait && s0.s0_write) begin
          w_we     = 1'b1;
          w_addr_n = r_addr + AW'(1);
          w_rem_n  = r_rem - BURST_W'(1);
          if (r_rem == BURST_W'(1)) w_state_n = IDLE;
        end
      end
      RD_WAIT: begin
        if (r_lat == 2'd0) begin
          w_fire    = 1'b1;
          w_addr_n  = r_addr + AW'(1);
          w_rem_n   = r_rem - BURST_W'(1);
          w_state_n = RD_BURST;
        end else begin
          w_lat_n = r_lat - 2'd1;
        end
      end
      RD_BURST: begin
        // r_rem counts beats not yet issued; the final beat is on the bus while it reads 0.
        if (r_rem != '0) begin
          w_fire   = 1'b1;
          w_addr_n = r_addr + AW'(1);
          w_rem_n  = r_rem - BURST_W'(1);
        end else begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Burst address, beat count, latency count, and the registered read port.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_addr   <= '0;
      r_rem    <= '0;
      r_lat    <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_addr   <= w_addr_n;
      r_rem    <= w_rem_n;
      r_lat    <= w_lat_n;
      r_ready  <= 1'b1;
      r_rvalid <= w_fire;
      if (w_fire) r_rdata <= r_mem[w_raddr];
    end
  end

  // RAM write, lane-wise; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (s0.s0_byteEnable[b]) r_mem[w_waddr][8*b +: 8] <= s0.s0_writeData[8*b +: 8];
    end
  end

  assign s0.s0_waitRequest   = w_wait;
  assign s0.s0_readData      = r_rdata;
  assign s0.s0_readDataValid = r_rvalid;
endmodule

// File: tb/tb_cache_mem_burst_slave.sv
// Directed bench for cache_mem_burst_slave (DEPTH=1024, BURST_W=8, READ_LAT=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cache_mem_burst_slave;
  logic clk = 1'b0;
  logic rest = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cache_mem_burst_slave_if #(.BURST_W(8)) bus ();

  cache_mem_burst_slave #(.DEPTH(1024), .BURST_W(8), .READ_LAT(2)) dut (
    .clk  (clk),
    .rest (rest),
    .s0   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    bus.s0_read = 1'b0;
    bus.s0_write = 1'b0;
    bus.s0_beginBurstTransfer = 1'b0;
  endtask

  // Hold the driven command until the edge that accepts it; bounded.
  task automatic wait_accept(input string tag);
    int n = 0;
    while (bus.s0_waitRequest !== 1'b0 && n < 40) begin step(); n++; end
    chk({tag, "_accept"}, 32'(n < 40), 32'd1);
    step();
  endtask

  task automatic wr_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [7:0] bc, input logic first);
    bus.s0_read = 1'b0;
    bus.s0_write = 1'b1;
    bus.s0_address = a;
    bus.s0_writeData = d;
    bus.s0_byteEnable = be;
    bus.s0_burstCount = bc;
    bus.s0_beginBurstTransfer = first;
    wait_accept("wr");
  endtask

  task automatic rd_issue(input string tag, input logic [31:0] a, input logic [7:0] bc);
    drive_idle();
    bus.s0_read = 1'b1;
    bus.s0_address = a;
    bus.s0_burstCount = bc;
    bus.s0_beginBurstTransfer = 1'b1;
    wait_accept(tag);
    drive_idle();
  endtask

  // Read burst with exact latency, contiguous beats, and return to IDLE.
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [7:0] bc, input int n,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    rd_issue(tag, a, bc);
    chk({tag, "_lat_gap"}, 32'(bus.s0_readDataValid), 32'd0);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s_vld%0d", tag, i), 32'(bus.s0_readDataValid), 32'd1);
      chk($sformatf("%s_dat%0d", tag, i), bus.s0_readData, e[i]);
    end
    step();
    chk({tag, "_vld_end"}, 32'(bus.s0_readDataValid), 32'd0);
    chk({tag, "_wait_end"}, 32'(bus.s0_waitRequest), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired; errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    bus.s0_address = '0;
    bus.s0_writeData = '0;
    bus.s0_byteEnable = '0;
    bus.s0_burstCount = '0;

    // Reset state.
    step(); step();
    chk("rst_wait", 32'(bus.s0_waitRequest), 32'd1);
    chk("rst_vld", 32'(bus.s0_readDataValid), 32'd0);
    chk("rst_data", bus.s0_readData, 32'd0);
    rest = 1'b1;
    step();
    chk("rel_wait", 32'(bus.s0_waitRequest), 32'd0);

    // Burst round trip, read issued the cycle after the last write beat.
    wr_beat(32'h100, 32'h11, 4'hF, 8'd4, 1'b1);
    wr_beat(32'h0,   32'h22, 4'hF, 8'd4, 1'b0);
    wr_beat(32'h0,   32'h33, 4'hF, 8'd4, 1'b0);
    wr_beat(32'h0,   32'h44, 4'hF, 8'd4, 1'b0);
    rd_chk("burst", 32'h100, 8'd4, 4, 32'h11, 32'h22, 32'h33, 32'h44);

    // Byte lanes.
    wr_beat(32'h200, 32'hAABBCCDD, 4'hF, 8'd1, 1'b1);
    wr_beat(32'h200, 32'h00000011, 4'b0001, 8'd1, 1'b1);
    drive_idle();
    step();
    rd_chk("lanes", 32'h200, 8'd1, 1, 32'hAABBCC11, 32'h0, 32'h0, 32'h0);

    // Wrap at the top of RAM with a 3-cycle gap after beat 2.
    wr_beat(32'hFF8, 32'hA0, 4'hF, 8'd4, 1'b1);
    wr_beat(32'h0,   32'hA1, 4'hF, 8'd4, 1'b0);
    drive_idle();
    step(); step(); step();
    chk("gap_wait", 32'(bus.s0_waitRequest), 32'd0);
    wr_beat(32'h0,   32'hA2, 4'hF, 8'd4, 1'b0);
    wr_beat(32'h0,   32'hA3, 4'hF, 8'd4, 1'b0);
    rd_chk("wrap", 32'hFF8, 8'd4, 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    rd_chk("word0", 32'h000, 8'd1, 1, 32'hA2, 32'h0, 32'h0, 32'h0);
    rd_chk("word1", 32'h004, 8'd1, 1, 32'hA3, 32'h0, 32'h0, 32'h0);

    // Zero burst count reads a single beat.
    rd_chk("bc0", 32'h100, 8'd0, 1, 32'h11, 32'h0, 32'h0, 32'h0);

    // Reset two beats into a four-beat read.
    rd_issue("abort", 32'h100, 8'd4);
    step();
    chk("abort_b0", bus.s0_readData, 32'h11);
    step();
    chk("abort_b1", bus.s0_readData, 32'h22);
    rest = 1'b0;
    #1;
    chk("abort_vld", 32'(bus.s0_readDataValid), 32'd0);
    chk("abort_wait", 32'(bus.s0_waitRequest), 32'd1);
    chk("abort_data", bus.s0_readData, 32'd0);
    step();
    rest = 1'b1;
    step();
    chk("abort_rel_wait", 32'(bus.s0_waitRequest), 32'd0);
    rd_chk("reread", 32'h100, 8'd1, 1, 32'h11, 32'h0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
